// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
//   Shares the single-port framebuffer BRAM between the camera write path
//   (pixel FIFO drain) and the display read path (random-address reads).
//   Reads win by default. After MAX_RD_STREAK back-to-back grants with
//   pixels waiting, one write slot is forced so the FIFO cannot overflow.
//   Write addresses run sequentially, wrap at FRAME_PIXELS-1 and are
//   realigned to 0 by i_frame_start.
//
// Ports
//   i_clk, i_rstn              memory-domain clock, async active-low reset
//   i_frame_start              vsync pulse, next write address becomes 0
//   i_fifo_empty, o_fifo_rd,
//   i_fifo_rdata               pixel FIFO read side (data one cycle after pop)
//   i_rd_req, i_rd_addr,
//   o_rd_gnt                   display read request / accept
//   o_rd_valid, o_rd_data      read return, 2 cycles after the grant
//   o_mem_we, o_mem_addr,
//   o_mem_wdata, i_mem_rdata   BRAM port (1-cycle read latency)
//   o_wr_addr                  current write address (status)
//   o_frame_done               pulses with the write of the last pixel
module fb_port_arbiter #(
    parameter int DATA_W        = 12,
    parameter int ADDR_W        = 19,
    parameter int FRAME_PIXELS  = 307200,
    parameter int MAX_RD_STREAK = 4
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_frame_start,
    input  logic              i_fifo_empty,
    output logic              o_fifo_rd,
    input  logic [DATA_W-1:0] i_fifo_rdata,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_gnt,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_frame_done
);

    localparam int SW = $clog2(MAX_RD_STREAK + 1);
    localparam logic [SW-1:0]     STREAK_MAX = SW'(MAX_RD_STREAK);
    localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(FRAME_PIXELS - 1);

    logic              wr_pend_q, wr_pend_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [1:0]        vld_pipe_q;          // [0]: grant issued, [1]: data registered
    logic [DATA_W-1:0] rd_data_q;

    logic streak_max, force_wr, pop, gnt, last_pix;

    always_comb begin
        streak_max = (streak_q == STREAK_MAX);
        force_wr   = streak_max && !i_fifo_empty;
        // Combinational outputs are gated by reset so every output is 0
        // while i_rstn is low, not just the registered ones.
        pop        = i_rstn && !i_fifo_empty && (!i_rd_req || streak_max);
        gnt        = i_rstn && !wr_pend_q && i_rd_req && !force_wr;
        last_pix   = (waddr_q == LAST_PIX);

        wr_pend_d = pop;

        waddr_d = waddr_q;
        if (wr_pend_q)
            waddr_d = last_pix ? '0 : waddr_q + 1'b1;
        // Realignment wins over the increment; a same-cycle commit still
        // uses the old address because the port sees waddr_q.
        if (i_frame_start)
            waddr_d = '0;

        streak_d = streak_q;
        if (pop || i_fifo_empty)
            streak_d = '0;
        else if (gnt && !streak_max)
            streak_d = streak_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_pend_q  <= 1'b0;
            waddr_q    <= '0;
            streak_q   <= '0;
            vld_pipe_q <= '0;
            rd_data_q  <= '0;
        end else begin
            wr_pend_q  <= wr_pend_d;
            waddr_q    <= waddr_d;
            streak_q   <= streak_d;
            vld_pipe_q <= {vld_pipe_q[0], gnt};
            if (vld_pipe_q[0])
                rd_data_q <= i_mem_rdata;
        end
    end

    // A pending pop owns the port; wr_pend_q is cleared by reset so a
    // popped-but-uncommitted word is simply dropped.
    assign o_fifo_rd    = pop;
    assign o_rd_gnt     = gnt;
    assign o_mem_we     = wr_pend_q;
    assign o_mem_addr   = wr_pend_q ? waddr_q : (gnt ? i_rd_addr : '0);
    assign o_mem_wdata  = wr_pend_q ? i_fifo_rdata : '0;
    assign o_frame_done = wr_pend_q && last_pix;
    assign o_rd_valid   = vld_pipe_q[1];
    assign o_rd_data    = rd_data_q;
    assign o_wr_addr    = waddr_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter. The FIFO and BRAM are modelled
// inside the cycle task; frame size is shrunk so the wrap is reachable.
module tb_fb_port_arbiter;

    localparam int DW = 12;
    localparam int AW = 19;
    localparam int FP = 1300;

    logic          i_clk = 1'b0;
    logic          i_rstn;
    logic          i_frame_start;
    logic          i_fifo_empty;
    logic          o_fifo_rd;
    logic [DW-1:0] i_fifo_rdata;
    logic          i_rd_req;
    logic [AW-1:0] i_rd_addr;
    logic          o_rd_gnt;
    logic          o_rd_valid;
    logic [DW-1:0] o_rd_data;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata;
    logic [AW-1:0] o_wr_addr;
    logic          o_frame_done;

    fb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FRAME_PIXELS(FP), .MAX_RD_STREAK(4)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_frame_start(i_frame_start),
        .i_fifo_empty(i_fifo_empty), .o_fifo_rd(o_fifo_rd), .i_fifo_rdata(i_fifo_rdata),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_gnt(o_rd_gnt),
        .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
        .o_wr_addr(o_wr_addr), .o_frame_done(o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] mem [0:2047];

    logic          obs_rd, obs_gnt, obs_we, obs_fd, obs_rv;
    logic [AW-1:0] obs_addr, obs_wa;
    logic [DW-1:0] obs_wd, obs_rdat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: sample at the falling edge, then update FIFO/BRAM models
    // just after the rising edge.
    task automatic clk_cyc();
        @(negedge i_clk);
        obs_rd = o_fifo_rd;  obs_gnt = o_rd_gnt;  obs_we = o_mem_we;
        obs_fd = o_frame_done; obs_rv = o_rd_valid; obs_rdat = o_rd_data;
        obs_addr = o_mem_addr; obs_wd = o_mem_wdata; obs_wa = o_wr_addr;
        @(posedge i_clk);
        #1;
        i_mem_rdata = mem[obs_addr[10:0]];
        if (obs_we) mem[obs_addr[10:0]] = obs_wd;
        if (obs_rd && fifo_q.size() > 0) i_fifo_rdata = fifo_q.pop_front();
        i_fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        i_fifo_empty = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) clk_cyc();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        i_rstn = 1'b0; i_frame_start = 1'b0; i_fifo_empty = 1'b0;
        i_fifo_rdata = '0; i_rd_req = 1'b1; i_rd_addr = 19'd55; i_mem_rdata = '0;
        #2;
        // reset: everything 0 even with requests pending
        chk("rst_fifo_rd", o_fifo_rd, 0);
        chk("rst_gnt", o_rd_gnt, 0);
        chk("rst_we", o_mem_we, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_wa", o_wr_addr, 0);
        chk("rst_rv", o_rd_valid, 0);
        i_rd_req = 1'b0; i_fifo_empty = 1'b1;
        @(posedge i_clk); #1;
        i_rstn = 1'b1;

        // writes only: 8 pops, writes to 0..7 one cycle later
        for (int i = 1; i <= 8; i++) push(DW'(i));
        for (int k = 0; k < 10; k++) begin
            clk_cyc();
            chk("wo_pop", obs_rd, (k < 8));
            chk("wo_we", obs_we, (k > 0 && k < 9));
            chk("wo_gnt", obs_gnt, 0);
            if (k > 0 && k < 9) begin
                chk("wo_addr", obs_addr, k - 1);
                chk("wo_data", obs_wd, k);
            end
        end

        // reads only
        mem[100] = 12'hA5A; mem[101] = 12'h5A5; mem[102] = 12'h3C3;
        i_rd_req = 1'b1; i_rd_addr = 19'd100;
        for (int c = 0; c < 6; c++) begin
            clk_cyc();
            chk("rd_gnt", obs_gnt, (c < 3));
            chk("rd_we", obs_we, 0);
            if (c < 3) chk("rd_addr", obs_addr, 100 + c);
            chk("rd_valid", obs_rv, (c >= 2 && c <= 4));
            if (c == 2) chk("rd_data0", obs_rdat, 12'hA5A);
            if (c == 3) chk("rd_data1", obs_rdat, 12'h5A5);
            if (c == 4) chk("rd_data2", obs_rdat, 12'h3C3);
            if (c < 2) i_rd_addr = i_rd_addr + 1'b1;
            if (c == 2) i_rd_req = 1'b0;
        end

        // starvation: 4 grants, forced pop, commit slot, repeat
        for (int i = 0; i < 20; i++) push(DW'(12'h100 + i));
        i_rd_req = 1'b1; i_rd_addr = 19'd200;
        for (int c = 0; c < 12; c++) begin
            clk_cyc();
            chk("st_gnt", obs_gnt, ((c % 6) < 4));
            chk("st_pop", obs_rd, ((c % 6) == 4));
            chk("st_we", obs_we, ((c % 6) == 5));
            if ((c % 6) == 5) begin
                chk("st_addr", obs_addr, 8 + c / 6);
                chk("st_data", obs_wd, 12'h100 + c / 6);
            end
        end
        i_rd_req = 1'b0;
        run(22);
        chk("st_wa", o_wr_addr, 28);

        // frame_start coincident with the commit at 1234
        for (int i = 0; i < 1206; i++) push(DW'(i));
        run(1210);
        chk("fs_wa_pre", o_wr_addr, 1234);
        push(12'hF01); push(12'hF02);
        clk_cyc();
        chk("fs_pop", obs_rd, 1);
        i_frame_start = 1'b1;
        clk_cyc();
        i_frame_start = 1'b0;
        chk("fs_we0", obs_we, 1);
        chk("fs_addr0", obs_addr, 1234);
        chk("fs_data0", obs_wd, 12'hF01);
        chk("fs_fd0", obs_fd, 0);
        clk_cyc();
        chk("fs_addr1", obs_addr, 0);
        chk("fs_data1", obs_wd, 12'hF02);
        chk("fs_fd1", obs_fd, 0);
        clk_cyc();
        chk("fs_wa_post", obs_wa, 1);

        // wrap at FP-1
        for (int i = 0; i < FP - 2; i++) push(DW'(i));
        run(FP + 2);
        chk("wr_wa_pre", o_wr_addr, FP - 1);
        push(12'hE01); push(12'hE02);
        clk_cyc();
        chk("wr_fd_pop", obs_fd, 0);
        clk_cyc();
        chk("wr_we", obs_we, 1);
        chk("wr_addr_last", obs_addr, FP - 1);
        chk("wr_fd", obs_fd, 1);
        clk_cyc();
        chk("wr_addr_zero", obs_addr, 0);
        chk("wr_data_zero", obs_wd, 12'hE02);
        chk("wr_fd_after", obs_fd, 0);

        // reset right after a pop: the popped word never reaches the BRAM
        push(12'hD01);
        clk_cyc();
        chk("rs_pop", obs_rd, 1);
        i_rstn = 1'b0; i_rd_req = 1'b1;
        #1;
        chk("rs_we", o_mem_we, 0);
        chk("rs_wdata", o_mem_wdata, 0);
        chk("rs_gnt", o_rd_gnt, 0);
        chk("rs_wa", o_wr_addr, 0);
        chk("rs_rdata", o_rd_data, 0);
        chk("rs_fd", o_frame_done, 0);
        for (int c = 0; c < 2; c++) begin
            clk_cyc();
            chk("rs_we_hold", obs_we, 0);
        end
        i_rd_req = 1'b0;
        i_rstn = 1'b1;
        push(12'h777); push(12'h778);
        clk_cyc();
        chk("rs_pop2", obs_rd, 1);
        clk_cyc();
        chk("rs_addr0", obs_addr, 0);
        chk("rs_data0", obs_wd, 12'h777);
        clk_cyc();
        chk("rs_addr1", obs_addr, 1);
        chk("rs_data1", obs_wd, 12'h778);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Schedules the single-port 12-bit framebuffer BRAM between two requesters: the camera write path (drains the pixel FIFO) and the display read path (random-address reads).
- Read requests have priority. A bounded-streak rule guarantees write bandwidth.
- Generates sequential write addresses with frame wrap and frame-start realignment.
- Sits in the 75 MHz memory domain, between the FIFO read side and the framebuffer BRAM.

Parameters:
- DATA_W, 12, pixel width (RGB444)
- ADDR_W, 19, framebuffer address width
- FRAME_PIXELS, 307200, pixels per frame (640x480); write address wraps from FRAME_PIXELS-1 to 0
- MAX_RD_STREAK, 4, maximum consecutive read grants while the FIFO is non-empty before one write slot is forced

Ports:
- i_clk, in, 1, memory-domain clock
- i_rstn, in, 1, asynchronous active-low reset
- i_frame_start, in, 1, one-cycle pulse (synchronized vsync rising edge); realigns the write address to 0
- i_fifo_empty, in, 1, pixel FIFO empty flag
- o_fifo_rd, out, 1, FIFO pop; data is valid on i_fifo_rdata one cycle later
- i_fifo_rdata, in, DATA_W, FIFO read data
- i_rd_req, in, 1, display read request; held until granted
- i_rd_addr, in, ADDR_W, display read address; stable while i_rd_req is high
- o_rd_gnt, out, 1, read accepted this cycle
- o_rd_valid, out, 1, read data valid; 2 cycles after the grant
- o_rd_data, out, DATA_W, read data
- o_mem_we, out, 1, BRAM write enable
- o_mem_addr, out, ADDR_W, BRAM address (read or write)
- o_mem_wdata, out, DATA_W, BRAM write data
- i_mem_rdata, in, DATA_W, BRAM read data; 1-cycle latency from the address
- o_wr_addr, out, ADDR_W, next write address (status)
- o_frame_done, out, 1, one-cycle pulse when the pixel at FRAME_PIXELS-1 is written

Behaviour:
- Reset: all outputs 0, write address 0, streak counter 0, pending-pop flag 0, read pipeline cleared.
- Reset mid-operation: a popped but uncommitted FIFO word is discarded, and no BRAM write occurs for it.
- Two-stage write pipeline:
  - Cycle t: pop (o_fifo_rd=1), sets wr_pend.
  - Cycle t+1: o_mem_we=1, o_mem_addr=waddr, o_mem_wdata=i_fifo_rdata; waddr advances.
- Port ownership at cycle t:
  - If wr_pend=1, the port belongs to the write; o_rd_gnt=0 regardless of i_rd_req.
  - Otherwise, if i_rd_req=1 and no forced write slot, grant the read: o_rd_gnt=1, o_mem_addr=i_rd_addr, o_mem_we=0.
- Read return: BRAM data is registered into o_rd_data with o_rd_valid=1 exactly 2 cycles after the grant. Back-to-back grants give back-to-back valids.
- Pop decision at cycle t: o_fifo_rd=1 iff i_fifo_empty=0 and (i_rd_req=0 or streak==MAX_RD_STREAK). Pops may occur every cycle, giving one write per cycle sustained while there are no reads.
- Streak counter:
  - Increments on each read grant while i_fifo_empty=0.
  - Clears on a pop, or when i_fifo_empty=1.
  - Saturates at MAX_RD_STREAK.
  - When it equals MAX_RD_STREAK with the FIFO non-empty, a pop is forced; the read waits one extra cycle for the write-commit slot.
- A pop and a read grant in the same cycle are legal: the pop affects only the next cycle.
- Write address wrap: a commit at waddr==FRAME_PIXELS-1 sets waddr to 0 and pulses o_frame_done in the same cycle as o_mem_we.
- i_frame_start handling:
  - Next write address becomes 0. If a commit occurs in the same cycle, the commit uses the old waddr and the following write uses 0.
  - No o_frame_done is generated from frame_start itself.
- o_wr_addr reflects waddr, registered.
- Read addresses ≥ FRAME_PIXELS are granted normally; no range checking.

Test Plan:
- Writes only: 8 FIFO words 0x001..0x008, i_rd_req=0 -> 8 pops on consecutive cycles; writes to addresses 0..7 with matching data one cycle after each pop; o_rd_gnt never asserted.
- Reads only: FIFO empty, i_rd_req held with addr 100,101,102 (BRAM preloaded) -> grants on 3 consecutive cycles; o_rd_valid on 3 consecutive cycles starting 2 cycles after the first grant, data in order.
- Starvation: continuous i_rd_req with FIFO non-empty and MAX_RD_STREAK=4 -> 4 grants, then a forced pop, then 1 cycle with o_rd_gnt=0 and o_mem_we=1; the pattern repeats.
- Wrap: preset waddr near the end and write pixel 307199 -> o_frame_done pulses with the write; the next write goes to address 0.
- i_frame_start at waddr=1234 coincident with a commit -> commit at 1234; the following write at address 0.
- Reset: assert i_rstn=0 in the cycle after a pop -> no o_mem_we; all outputs 0 asynchronously; after release the first write goes to address 0.
